// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, stuffed-zero removal and LSB-first byte framing.
// Defining HDLC_RX_IDLE_DETECT_EN builds the raw-line idle detector behind Rx_Idle.
module hdlc_rx_deframer #(
  parameter int MAX_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RxEN,
  input  logic       Rx,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic       Rx_NewByte,
  output logic [7:0] Rx_Data,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic       Rx_Overflow,
  output logic       Rx_Idle
);

  typedef enum logic [1:0] {IDLE, HUNT, RECV} state_t;

  localparam logic [7:0] FLAG    = 8'h7E;
  localparam logic [7:0] ABORT   = 8'hFE;
  localparam logic [7:0] MAX_CNT = MAX_BYTES[7:0];

  state_t     state_q;
  logic [7:0] sh_q;
  logic [2:0] skip_q;
  logic [2:0] bitCnt_q;
  logic [7:0] byteCnt_q;
  logic [2:0] onesCnt_q;
  logic [7:0] asm_q;
  logic [7:0] data_q;
  logic       flagDet_q;
  logic       abortDet_q;
  logic       validFrame_q;
  logic       newByte_q;
  logic       eof_q;
  logic       frameErr_q;
  logic       overflow_q;
  logic       closePend_q;
  logic       endPend_q;
  logic       closeErr_q;

  logic       isFlag;
  logic       isAbort;
  logic       dropBit;
  logic [7:0] sh_d;
  logic [7:0] byte_d;

  // sh_q is an 8-bit look-ahead window: a flag or abort is recognised before any of its bits are consumed
  assign sh_d    = {Rx, sh_q[7:1]};
  assign isFlag  = (sh_q == FLAG);
  assign isAbort = (sh_q == ABORT);
  assign dropBit = ~sh_q[0] && (onesCnt_q == 3'd5);
  assign byte_d  = {sh_q[0], asm_q[7:1]};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      sh_q         <= 8'h00;
      skip_q       <= '0;
      bitCnt_q     <= '0;
      byteCnt_q    <= '0;
      onesCnt_q    <= '0;
      asm_q        <= '0;
      data_q       <= '0;
      flagDet_q    <= 1'b0;
      abortDet_q   <= 1'b0;
      validFrame_q <= 1'b0;
      newByte_q    <= 1'b0;
      eof_q        <= 1'b0;
      frameErr_q   <= 1'b0;
      overflow_q   <= 1'b0;
      closePend_q  <= 1'b0;
      endPend_q    <= 1'b0;
      closeErr_q   <= 1'b0;
    end else if (!RxEN) begin
      state_q      <= IDLE;
      skip_q       <= '0;
      bitCnt_q     <= '0;
      byteCnt_q    <= '0;
      onesCnt_q    <= '0;
      flagDet_q    <= 1'b0;
      abortDet_q   <= 1'b0;
      validFrame_q <= 1'b0;
      newByte_q    <= 1'b0;
      eof_q        <= 1'b0;
      frameErr_q   <= 1'b0;
      closePend_q  <= 1'b0;
      endPend_q    <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      flagDet_q  <= isFlag;
      abortDet_q <= isAbort;
      newByte_q  <= 1'b0;
      // Frame close runs as a pipeline: detect, drop ValidFrame, then pulse EoF
      closePend_q <= 1'b0;
      endPend_q   <= closePend_q;
      eof_q       <= endPend_q;
      frameErr_q  <= endPend_q && closeErr_q;
      if (closePend_q) validFrame_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (isFlag) begin
            state_q   <= HUNT;
            skip_q    <= 3'd7;
            bitCnt_q  <= '0;
            byteCnt_q <= '0;
            onesCnt_q <= '0;
          end
        end
        HUNT: begin
          if (isAbort) begin
            state_q <= IDLE;
          end else if (isFlag) begin
            skip_q <= 3'd7;
          end else begin
            skip_q <= skip_q - 3'd1;
            if (skip_q == 3'd1) state_q <= RECV;
          end
        end
        RECV: begin
          if (isAbort) begin
            state_q <= IDLE;
            if (validFrame_q) begin
              closePend_q <= 1'b1;
              closeErr_q  <= 1'b0;
            end
          end else if (isFlag) begin
            state_q   <= HUNT;
            skip_q    <= 3'd7;
            bitCnt_q  <= '0;
            byteCnt_q <= '0;
            onesCnt_q <= '0;
            if (validFrame_q) begin
              closePend_q <= 1'b1;
              closeErr_q  <= (bitCnt_q != 3'd0);
            end
          end else if (dropBit) begin
            onesCnt_q <= '0;
          end else begin
            onesCnt_q <= !sh_q[0] ? 3'd0 :
                         (onesCnt_q == 3'd7) ? 3'd7 : onesCnt_q + 3'd1;
            asm_q     <= byte_d;
            bitCnt_q  <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              // Once the limit is hit, every later byte of the frame is swallowed
              if (byteCnt_q == MAX_CNT) begin
                overflow_q <= 1'b1;
              end else begin
                newByte_q    <= 1'b1;
                data_q       <= byte_d;
                byteCnt_q    <= byteCnt_q + 8'd1;
                validFrame_q <= 1'b1;
                if (byteCnt_q == 8'd0) overflow_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Rx_FlagDetect  = flagDet_q;
  assign Rx_AbortDetect = abortDet_q;
  assign Rx_ValidFrame  = validFrame_q;
  assign Rx_NewByte     = newByte_q;
  assign Rx_Data        = data_q;
  assign Rx_EoF         = eof_q;
  assign Rx_FrameError  = frameErr_q;
  assign Rx_Overflow    = overflow_q;

`ifdef HDLC_RX_IDLE_DETECT_EN
  logic [3:0] idleCnt_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      idleCnt_q <= '0;
    end else if (RxEN) begin
      if (!Rx) idleCnt_q <= '0;
      else if (idleCnt_q != 4'hF) idleCnt_q <= idleCnt_q + 4'd1;
    end
  end

  assign Rx_Idle = (idleCnt_q == 4'hF);
`else
  assign Rx_Idle = 1'b0;
`endif

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Scoreboard bench for hdlc_rx_deframer: stimulus queues timed events, a negedge monitor matches them.
module tb_hdlc_rx_deframer;

  localparam int MAX_BYTES = 4;

  logic       Clk  = 1'b0;
  logic       Rst  = 1'b0;
  logic       RxEN = 1'b0;
  logic       Rx   = 1'b0;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_ValidFrame;
  logic       Rx_NewByte;
  logic [7:0] Rx_Data;
  logic       Rx_EoF;
  logic       Rx_FrameError;
  logic       Rx_Overflow;
  logic       Rx_Idle;

  hdlc_rx_deframer #(.MAX_BYTES(MAX_BYTES)) dut (
    .Clk(Clk), .Rst(Rst), .RxEN(RxEN), .Rx(Rx),
    .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
    .Rx_ValidFrame(Rx_ValidFrame), .Rx_NewByte(Rx_NewByte), .Rx_Data(Rx_Data),
    .Rx_EoF(Rx_EoF), .Rx_FrameError(Rx_FrameError), .Rx_Overflow(Rx_Overflow),
    .Rx_Idle(Rx_Idle)
  );

  always #5 Clk = ~Clk;

  // Kind order doubles as the order the monitor inspects events within one cycle
  typedef enum int {K_VF_FALL = 0, K_FLAG, K_ABORT, K_VF_RISE, K_BYTE, K_EOF, K_OVF_RISE, K_OVF_FALL} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t expQ[$];
  int   edgeCnt  = 0;
  int   lastEdge = 0;
  int   checks   = 0;
  int   fails    = 0;
  logic prevVf   = 1'b0;
  logic prevOvf  = 1'b0;

  always @(posedge Clk) edgeCnt <= edgeCnt + 1;

  task automatic pushExp(input kind_t k, input logic [7:0] d, input int c);
    exp_t e;
    int   idx;
    logic found;
    e.kind = k;
    e.data = d;
    e.cyc  = c;
    idx    = expQ.size();
    found  = 1'b0;
    for (int i = 0; i < expQ.size(); i++) begin
      if (!found && (expQ[i].cyc > c || (expQ[i].cyc == c && expQ[i].kind > k))) begin
        idx   = i;
        found = 1'b1;
      end
    end
    expQ.insert(idx, e);
  endtask

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: actual %h, required %h", name, act, req);
    end
  endtask

  task automatic checkOutput(input kind_t k, input logic [7:0] d);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      fails++;
      $display("[TB] FAIL unexpected_%s: actual data %h at cycle %0d, required no event", k.name(), d, edgeCnt);
    end else begin
      e = expQ.pop_front();
      if (e.kind != k || e.data !== d || e.cyc != edgeCnt) begin
        fails++;
        $display("[TB] FAIL event_%s: actual %s data %h cycle %0d, required %s data %h cycle %0d",
                 e.kind.name(), k.name(), d, edgeCnt, e.kind.name(), e.data, e.cyc);
      end
    end
  endtask

  // Monitor: retire overdue expectations, then match every observed event in kind order
  always @(negedge Clk) begin
    while (expQ.size() > 0 && expQ[0].cyc < edgeCnt) begin
      exp_t e;
      e = expQ.pop_front();
      checks++;
      fails++;
      $display("[TB] FAIL missing_%s: actual none, required data %h at cycle %0d", e.kind.name(), e.data, e.cyc);
    end
    if (prevVf && !Rx_ValidFrame)  checkOutput(K_VF_FALL, 8'h00);
    if (Rx_FlagDetect)             checkOutput(K_FLAG, 8'h00);
    if (Rx_AbortDetect)            checkOutput(K_ABORT, 8'h00);
    if (!prevVf && Rx_ValidFrame)  checkOutput(K_VF_RISE, 8'h00);
    if (Rx_NewByte)                checkOutput(K_BYTE, Rx_Data);
    if (Rx_EoF)                    checkOutput(K_EOF, {7'd0, Rx_FrameError});
    if (!prevOvf && Rx_Overflow)   checkOutput(K_OVF_RISE, 8'h00);
    if (prevOvf && !Rx_Overflow)   checkOutput(K_OVF_FALL, 8'h00);
    if (Rx_FrameError && !Rx_EoF)  checkValue("frame_error_without_eof", 8'h01, 8'h00);
    prevVf  = Rx_ValidFrame;
    prevOvf = Rx_Overflow;
  end

  task automatic sendBit(input logic b);
    Rx = b;
    @(posedge Clk);
    #1;
    lastEdge = edgeCnt;
  endtask

  task automatic sendZeros(input int n);
    for (int i = 0; i < n; i++) sendBit(1'b0);
  endtask

  task automatic sendByte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
  endtask

  task automatic sendFlag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) sendBit(f[i]);
    pushExp(K_FLAG, 8'h00, lastEdge + 1);
  endtask

  // Closing flag of a frame that carried data: ValidFrame drops at k+2, EoF at k+3
  task automatic closeFrame(input logic err);
    sendFlag();
    pushExp(K_VF_FALL, 8'h00, lastEdge + 2);
    pushExp(K_EOF, {7'd0, err}, lastEdge + 3);
  endtask

  // Idle ones after a flag form an abort with the flag's last zero
  task automatic sendOnesAbort();
    for (int i = 0; i < 8; i++) begin
      sendBit(1'b1);
      if (i == 6) pushExp(K_ABORT, 8'h00, lastEdge + 1);
    end
  endtask

  task automatic sendDataByte(input logic [7:0] d, input logic first);
    sendByte(d);
    pushExp(K_BYTE, d, lastEdge + 8);
    if (first) pushExp(K_VF_RISE, 8'h00, lastEdge + 8);
  endtask

  task automatic applyStimulus();
    logic [8:0] stuffedFF;
    // Lone flag on an otherwise quiet line
    sendFlag();
    sendOnesAbort();
    sendZeros(4);

    // Two-byte frame
    sendFlag();
    sendDataByte(8'hA5, 1'b1);
    sendDataByte(8'h3C, 1'b0);
    closeFrame(1'b0);
    sendOnesAbort();
    sendZeros(4);

    // 0xFF with a stuffed zero after five ones
    sendFlag();
    stuffedFF = 9'b111_0_11111;
    for (int i = 0; i < 9; i++) sendBit(stuffedFF[i]);
    pushExp(K_BYTE, 8'hFF, lastEdge + 8);
    pushExp(K_VF_RISE, 8'h00, lastEdge + 8);
    closeFrame(1'b0);
    sendOnesAbort();
    sendZeros(4);

    // Abort after one byte
    sendFlag();
    sendDataByte(8'h12, 1'b1);
    sendBit(1'b0);
    for (int i = 0; i < 7; i++) sendBit(1'b1);
    pushExp(K_ABORT, 8'h00, lastEdge + 1);
    pushExp(K_VF_FALL, 8'h00, lastEdge + 2);
    pushExp(K_EOF, 8'h00, lastEdge + 3);
    sendZeros(4);

    // Non-aligned close: one byte plus four bits
    sendFlag();
    sendDataByte(8'h96, 1'b1);
    sendBit(1'b0); sendBit(1'b1); sendBit(1'b1); sendBit(1'b0);
    closeFrame(1'b1);
    sendOnesAbort();
    sendZeros(4);

    // Overflow with MAX_BYTES=4, then a fresh frame clears it
    sendFlag();
    sendDataByte(8'h11, 1'b1);
    sendDataByte(8'h22, 1'b0);
    sendDataByte(8'h33, 1'b0);
    sendDataByte(8'h44, 1'b0);
    sendByte(8'h55);
    pushExp(K_OVF_RISE, 8'h00, lastEdge + 8);
    closeFrame(1'b0);
    sendDataByte(8'h66, 1'b1);
    pushExp(K_OVF_FALL, 8'h00, lastEdge + 8);
    closeFrame(1'b0);
    sendOnesAbort();
    sendZeros(4);

    // RxEN low mid-frame drops ValidFrame without EoF
    sendFlag();
    sendDataByte(8'h5A, 1'b1);
    sendZeros(8);
    RxEN = 1'b0;
    sendBit(1'b0);
    pushExp(K_VF_FALL, 8'h00, lastEdge);
    RxEN = 1'b1;
    sendZeros(4);

    // Reset mid-frame drops ValidFrame immediately, no EoF
    sendFlag();
    sendDataByte(8'hA5, 1'b1);
    sendZeros(9);
    Rst = 1'b0;
    pushExp(K_VF_FALL, 8'h00, lastEdge);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    sendZeros(12);
  endtask

  initial begin
    int waitCnt;
    repeat (3) @(posedge Clk);
    #1;
    checkValue("reset_flag_abort", {6'd0, Rx_FlagDetect, Rx_AbortDetect}, 8'h00);
    checkValue("reset_valid_newbyte_eof", {5'd0, Rx_ValidFrame, Rx_NewByte, Rx_EoF}, 8'h00);
    checkValue("reset_data", Rx_Data, 8'h00);
    checkValue("reset_err_ovf_idle", {5'd0, Rx_FrameError, Rx_Overflow, Rx_Idle}, 8'h00);
    Rst  = 1'b1;
    RxEN = 1'b1;
    sendZeros(4);
    applyStimulus();
    waitCnt = 0;
    while (expQ.size() > 0 && waitCnt < 20) begin
      @(posedge Clk);
      waitCnt++;
    end
    @(negedge Clk);
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checks++;
      fails++;
      $display("[TB] FAIL timeout_%s: actual none, required data %h at cycle %0d", e.kind.name(), e.data, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
